// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: bus widths, state and access-width encodings shared by the memory controller.
package mem_ctrl_pkg;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int RAM_ADDR_W = 32;
    localparam int RAM_DATA_W = 8;
    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;
    typedef enum logic [1:0] {MEM_IDLE, MEM_READ, MEM_WRITE, MEM_DONE} mem_state_e;
    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        return w == WIDTH_BYTE ? 3'd1 : w == WIDTH_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and data requests onto a byte-wide synchronous RAM, serialising accesses into byte cycles.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_fe,
    input  logic [ADDR_W-1:0]     inst_fpc,
    output logic [DATA_W-1:0]     inst,
    output logic                  inst_ok,
    output logic [ADDR_W-1:0]     inst_pc,
    input  logic                  d_re,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [1:0]            d_width,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ok,
    input  logic [RAM_DATA_W-1:0] ram_din,
    output logic [RAM_DATA_W-1:0] ram_dout,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic                  ram_wr
);
    mem_state_e state_q, state_d;
    logic own_d_q, own_d_d, inst_ok_q, inst_ok_d, d_ok_q, d_ok_d, ram_wr_q, ram_wr_d;
    logic [2:0] n_q, n_d, cnt_q, cnt_d;
    logic [1:0] bi;
    logic [ADDR_W-1:0] addr_q, addr_d, inst_pc_q, inst_pc_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, asm_q, asm_d, asm_nxt, inst_q, inst_d, d_rdata_q, d_rdata_d;
    logic [RAM_ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [RAM_DATA_W-1:0] ram_dout_q, ram_dout_d;

    always_comb begin
        state_d    = state_q;
        own_d_d    = own_d_q;
        addr_d     = addr_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        d_rdata_d  = d_rdata_q;
        inst_ok_d  = 1'b0;
        d_ok_d     = 1'b0;
        ram_wr_d   = 1'b0;
        ram_a_d    = '0;
        ram_dout_d = '0;
        // ram_din in cycle cnt carries the byte addressed in cycle cnt-1
        bi         = cnt_q[1:0] - 2'd1;
        asm_nxt    = asm_q;
        asm_nxt[{bi, 3'b000} +: 8] = ram_din;
        case (state_q)
            MEM_IDLE: if (d_re || d_we || inst_fe) begin
                own_d_d    = d_re || d_we;
                addr_d     = own_d_d ? d_addr : inst_fpc;
                n_d        = own_d_d ? width_bytes(d_width) : 3'd4;
                wdata_d    = d_wdata;
                asm_d      = '0;
                cnt_d      = '0;
                ram_a_d    = addr_d;
                ram_wr_d   = d_we;
                ram_dout_d = d_we ? d_wdata[7:0] : '0;
                state_d    = d_we ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q != 3'd0) asm_d = asm_nxt;
                if (cnt_q == n_q) begin
                    state_d   = MEM_DONE;
                    cnt_d     = '0;
                    inst_ok_d = !own_d_q;
                    d_ok_d    = own_d_q;
                    inst_d    = own_d_q ? inst_q : asm_nxt;
                    inst_pc_d = own_d_q ? inst_pc_q : addr_q;
                    d_rdata_d = own_d_q ? asm_nxt : d_rdata_q;
                end else if (cnt_d < n_q) begin
                    ram_a_d = addr_q + {29'd0, cnt_d};
                end
            end
            MEM_WRITE: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_d == n_q) begin
                    state_d = MEM_DONE;
                    cnt_d   = '0;
                    d_ok_d  = 1'b1;
                end else begin
                    ram_a_d    = addr_q + {29'd0, cnt_d};
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[{cnt_d[1:0], 3'b000} +: 8];
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MEM_IDLE;
            own_d_q    <= 1'b0;
            addr_q     <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            d_rdata_q  <= '0;
            inst_ok_q  <= 1'b0;
            d_ok_q     <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            own_d_q    <= own_d_d;
            addr_q     <= addr_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            d_rdata_q  <= d_rdata_d;
            inst_ok_q  <= inst_ok_d;
            d_ok_q     <= d_ok_d;
            ram_wr_q   <= ram_wr_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
        end
    end

    assign inst     = inst_q;
    assign inst_pc  = inst_pc_q;
    assign inst_ok  = inst_ok_q;
    assign d_rdata  = d_rdata_q;
    assign d_ok     = d_ok_q;
    assign ram_a    = ram_a_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized transactions checked against a byte-array memory model.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic inst_fe, inst_ok, d_re, d_we, d_ok, ram_wr;
    logic [31:0] inst_fpc, inst, inst_pc, d_addr, d_wdata, d_rdata, ram_a;
    logic [1:0] d_width;
    logic [7:0] ram_din = 8'h00;
    logic [7:0] ram_dout;
    int checks = 0;
    int failures = 0;
    logic [7:0] mem [logic [31:0]];
    logic [7:0] sh [logic [31:0]];
    logic [31:0] exp_inst = 0, exp_pc = 0, exp_drd = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .inst_fe(inst_fe), .inst_fpc(inst_fpc), .inst(inst), .inst_ok(inst_ok), .inst_pc(inst_pc),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
        .d_rdata(d_rdata), .d_ok(d_ok),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin
        if (ram_wr) mem[ram_a] = ram_dout;
        ram_din <= mem.exists(ram_a) ? mem[ram_a] : init_byte(ram_a);
    end

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return sh.exists(a) ? sh[a] : init_byte(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_fe = 1'b0;
        d_re = 1'b0;
        d_we = 1'b0;
    endtask

    task automatic idle_chk();
        step();
        chk("idle_ram_a", ram_a, 32'h0);
        chk("idle_ram_wr", 32'(ram_wr), 32'h0);
        chk("idle_inst_ok", 32'(inst_ok), 32'h0);
        chk("idle_d_ok", 32'(d_ok), 32'h0);
    endtask

    // Called in the cycle the request is presented; returns in the completion cycle.
    // drop: 0 release after accept, 1 release at completion, 2 release data only at completion.
    task automatic xact(input bit dside, input bit wr, input logic [31:0] a, input logic [1:0] w,
                        input logic [31:0] wd, input int drop, input logic [31:0] chg);
        int n = !dside ? 4 : (w == 2'd0 ? 1 : w == 2'd1 ? 2 : 4);
        int last = wr ? n + 1 : n + 2;
        logic [31:0] rd = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (wr) sh[a + 32'(i)] = wd[8*i +: 8];
            else rd[8*i +: 8] = sh_rd(a + 32'(i));
        end
        for (int k = 1; k <= last; k++) begin
            step();
            if (k == 1 && drop == 0) idle_inputs();
            if (k == 2 && chg != 32'h0) inst_fpc = chg;
            if (k <= n) begin
                chk("ram_a", ram_a, a + 32'(k - 1));
                chk("ram_wr", 32'(ram_wr), 32'(wr));
                if (wr) chk("ram_dout", 32'(ram_dout), 32'(wd[8*(k-1) +: 8]));
            end
            chk("inst_ok", 32'(inst_ok), 32'(k == last && !dside));
            chk("d_ok", 32'(d_ok), 32'(k == last && dside));
        end
        if (!dside) begin
            exp_inst = rd;
            exp_pc = a;
        end else if (!wr) begin
            exp_drd = rd;
        end
        chk("done_ram_a", ram_a, 32'h0);
        chk("done_ram_wr", 32'(ram_wr), 32'h0);
        chk("inst", inst, exp_inst);
        chk("inst_pc", inst_pc, exp_pc);
        chk("d_rdata", d_rdata, exp_drd);
        if (drop == 1) idle_inputs();
        if (drop == 2) begin
            d_re = 1'b0;
            d_we = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int kind;
        int drop;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0] w;
        rst = 1'b1;
        idle_inputs();
        inst_fpc = 0; d_addr = 0; d_wdata = 0; d_width = 0;
        for (int i = 0; i < 4; i++) begin
            mem[32'h10 + 32'(i)] = 8'h13 - 8'(i);
            sh[32'h10 + 32'(i)] = 8'h13 - 8'(i);
        end
        step();
        step();
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_dout", 32'(ram_dout), 0);
        chk("rst_oks_wr", {29'b0, inst_ok, d_ok, ram_wr}, 0);
        rst = 1'b0;
        step();

        inst_fe = 1'b1; inst_fpc = 32'h10;
        xact(0, 0, 32'h10, 2'd2, 0, 1, 0);
        chk("fetch_lit", inst, 32'h10111213);
        idle_chk();

        inst_fe = 1'b1; inst_fpc = 32'h20;
        d_re = 1'b1; d_addr = 32'h100; d_width = 2'd2;
        xact(1, 0, 32'h100, 2'd2, 0, 2, 0);
        step();
        chk("arb_gap_inst_ok", 32'(inst_ok), 0);
        chk("arb_gap_ram_a", ram_a, 0);
        xact(0, 0, 32'h20, 2'd2, 0, 1, 0);
        idle_chk();

        d_we = 1'b1; d_addr = 32'h2001; d_wdata = 32'hAABBCCDD; d_width = 2'd0;
        xact(1, 1, 32'h2001, 2'd0, 32'hAABBCCDD, 1, 0);
        idle_chk();
        d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h00001234; d_width = 2'd1;
        xact(1, 1, 32'h2000, 2'd1, 32'h00001234, 0, 0);
        idle_chk();
        d_re = 1'b1; d_addr = 32'h2000; d_width = 2'd1;
        xact(1, 0, 32'h2000, 2'd1, 0, 1, 0);
        chk("half_lit", d_rdata, 32'h00001234);
        idle_chk();

        d_we = 1'b1; d_addr = 32'hFFFFFFFE; d_wdata = 32'hCAFEF00D; d_width = 2'd2;
        xact(1, 1, 32'hFFFFFFFE, 2'd2, 32'hCAFEF00D, 1, 0);
        idle_chk();
        d_re = 1'b1; d_addr = 32'hFFFFFFFE; d_width = 2'd3;
        xact(1, 0, 32'hFFFFFFFE, 2'd3, 0, 0, 0);
        chk("wrap_lit", d_rdata, 32'hCAFEF00D);
        idle_chk();

        inst_fe = 1'b1; inst_fpc = 32'h40;
        xact(0, 0, 32'h40, 2'd2, 0, 2, 32'h80);
        chk("pc_keep", inst_pc, 32'h40);
        step();
        xact(0, 0, 32'h80, 2'd2, 0, 1, 0);
        idle_chk();

        inst_fe = 1'b1; inst_fpc = 32'h50;
        step(); step(); step();
        chk("rst_mid_ram_a", ram_a, 32'h52);
        rst = 1'b1; inst_fe = 1'b0;
        step();
        rst = 1'b0;
        exp_inst = 0; exp_pc = 0; exp_drd = 0;
        chk("rstm_inst", inst, 0);
        chk("rstm_inst_pc", inst_pc, 0);
        chk("rstm_d_rdata", d_rdata, 0);
        chk("rstm_ram_a", ram_a, 0);
        chk("rstm_outs", {21'b0, ram_dout, inst_ok, d_ok, ram_wr}, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rstm_no_ok", {30'b0, inst_ok, d_ok}, 0);
        end
        inst_fe = 1'b1; inst_fpc = 32'h50;
        xact(0, 0, 32'h50, 2'd2, 0, 1, 0);
        idle_chk();

        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            drop = int'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                            : 32'h3000 + 32'($urandom_range(0, 63));
            w = 2'($urandom_range(0, 3));
            wd = $urandom;
            inst_fe = (kind == 0) || ($urandom_range(0, 1) == 1);
            inst_fpc = a;
            d_we = (kind == 2);
            d_re = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
            d_addr = a; d_wdata = wd; d_width = w;
            xact(kind != 0, kind == 2, a, w, wd, drop, 0);
            if (drop == 0 || drop == 1) idle_inputs();
            idle_chk();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
